// File: rtl/sprite_regfile_if.sv
// CPU-side register window bus for the sprite register bank.
// Latency: rdata is registered one clock after a read strobe.
// Backpressure: none, the bank accepts an access every clock.
interface sprite_regfile_if;
    logic        cs;
    logic        we;
    logic [5:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;

    modport master (
        output cs,
        output we,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  cs,
        input  we,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/sprite_regfile.sv
// Sprite shadow/active register bank with frame-synchronous atomic commit.
// Latency: reads 1 clk; active outputs update 2 clks after vsync rises while armed.
// Backpressure: none, every access completes; SPRITE_CLAMP_EN clamps positions to the 640x480 area.
module sprite_regfile #(
    parameter int unsigned SHIP_X0   = 100,
    parameter int unsigned SHIP_Y0   = 400,
    parameter int unsigned PLANET_X0 = 312,
    parameter int unsigned PLANET_Y0 = 40
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sprite_regfile_if.slave      bus,
    input  logic                 vsync_i,
    output logic                 commit_pending_o,
    output logic [15:0]          frame_cnt_o,
    output logic [15:0]          spaceship_x_o,
    output logic [15:0]          spaceship_y_o,
    output logic [15:0]          planet_x_o,
    output logic [15:0]          planet_y_o,
    output logic [15:0]          spaceship_bitmap_o [0:15],
    output logic [15:0]          planet_bitmap_o    [0:15]
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [5:0] A_SHIP_X   = 6'h00;
    localparam logic [5:0] A_SHIP_Y   = 6'h01;
    localparam logic [5:0] A_PLANET_X = 6'h02;
    localparam logic [5:0] A_PLANET_Y = 6'h03;
    localparam logic [5:0] A_CTRL     = 6'h04;
    localparam logic [5:0] A_STATUS   = 6'h05;

    // Horizontal positions limited so a 16-pixel sprite stays inside 640 columns,
    // vertical ones so it stays inside 480 lines.
    function automatic logic [15:0] clamp_x(input logic [15:0] v);
`ifdef SPRITE_CLAMP_EN
        return (v > 16'd624) ? 16'd624 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [15:0] clamp_y(input logic [15:0] v);
`ifdef SPRITE_CLAMP_EN
        return (v > 16'd464) ? 16'd464 : v;
`else
        return v;
`endif
    endfunction

    state_t      state_q, state_d;
    logic        pending_q;
    logic        vsync_q;
    logic [15:0] frame_cnt_q;
    logic [15:0] rdata_q, rdata_d;

    logic [15:0] ship_x_sh_q, ship_y_sh_q, planet_x_sh_q, planet_y_sh_q;
    logic [15:0] ship_x_q, ship_y_q, planet_x_q, planet_y_q;
    logic [15:0] ship_bmp_sh_q   [0:15];
    logic [15:0] planet_bmp_sh_q [0:15];
    logic [15:0] ship_bmp_q      [0:15];
    logic [15:0] planet_bmp_q    [0:15];

    logic wr_en, rd_en, ctrl_wr, commit_req, abort_req, vs_rise;

    assign wr_en      = bus.cs && bus.we;
    assign rd_en      = bus.cs && !bus.we;
    assign ctrl_wr    = wr_en && (bus.addr == A_CTRL);
    // A commit request with the abort bit also set is treated as an abort, never an arm.
    assign commit_req = ctrl_wr && bus.wdata[0] && !bus.wdata[1];
    assign abort_req  = ctrl_wr && bus.wdata[1];
    assign vs_rise    = vsync_i && !vsync_q;

    // Next-state logic; abort is checked before vs_rise so it wins a same-cycle race.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (commit_req) state_d = ARMED;
            ARMED: begin
                if (abort_req)    state_d = IDLE;
                else if (vs_rise) state_d = COMMIT;
            end
            COMMIT:  state_d = commit_req ? ARMED : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, pending flag, vsync edge detector and frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            vsync_q     <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= (state_d != IDLE);
            vsync_q   <= vsync_i;
            if (vs_rise) frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    // Software writes land in the shadow copies only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ship_x_sh_q   <= 16'(SHIP_X0);
            ship_y_sh_q   <= 16'(SHIP_Y0);
            planet_x_sh_q <= 16'(PLANET_X0);
            planet_y_sh_q <= 16'(PLANET_Y0);
            for (int i = 0; i < 16; i++) begin
                ship_bmp_sh_q[i]   <= '0;
                planet_bmp_sh_q[i] <= '0;
            end
        end else if (wr_en) begin
            case (bus.addr)
                A_SHIP_X:   ship_x_sh_q   <= clamp_x(bus.wdata);
                A_SHIP_Y:   ship_y_sh_q   <= clamp_y(bus.wdata);
                A_PLANET_X: planet_x_sh_q <= clamp_x(bus.wdata);
                A_PLANET_Y: planet_y_sh_q <= clamp_y(bus.wdata);
                default: begin
                    if (bus.addr[5:4] == 2'b01) ship_bmp_sh_q[bus.addr[3:0]]   <= bus.wdata;
                    if (bus.addr[5:4] == 2'b10) planet_bmp_sh_q[bus.addr[3:0]] <= bus.wdata;
                end
            endcase
        end
    end

    // Active copies take the whole shadow set at once, as it stood before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ship_x_q   <= 16'(SHIP_X0);
            ship_y_q   <= 16'(SHIP_Y0);
            planet_x_q <= 16'(PLANET_X0);
            planet_y_q <= 16'(PLANET_Y0);
            for (int i = 0; i < 16; i++) begin
                ship_bmp_q[i]   <= '0;
                planet_bmp_q[i] <= '0;
            end
        end else if (state_q == COMMIT) begin
            ship_x_q   <= ship_x_sh_q;
            ship_y_q   <= ship_y_sh_q;
            planet_x_q <= planet_x_sh_q;
            planet_y_q <= planet_y_sh_q;
            for (int i = 0; i < 16; i++) begin
                ship_bmp_q[i]   <= ship_bmp_sh_q[i];
                planet_bmp_q[i] <= planet_bmp_sh_q[i];
            end
        end
    end

    // Read mux: shadow values or STATUS; CTRL and unmapped addresses read as zero.
    always_comb begin
        rdata_d = '0;
        case (bus.addr)
            A_SHIP_X:   rdata_d = ship_x_sh_q;
            A_SHIP_Y:   rdata_d = ship_y_sh_q;
            A_PLANET_X: rdata_d = planet_x_sh_q;
            A_PLANET_Y: rdata_d = planet_y_sh_q;
            A_STATUS:   rdata_d = {frame_cnt_q[14:0], pending_q};
            default: begin
                if (bus.addr[5:4] == 2'b01) rdata_d = ship_bmp_sh_q[bus.addr[3:0]];
                if (bus.addr[5:4] == 2'b10) rdata_d = planet_bmp_sh_q[bus.addr[3:0]];
            end
        endcase
    end

    // Read data register holds its value between read strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rdata_q <= '0;
        else if (rd_en) rdata_q <= rdata_d;
    end

    assign bus.rdata          = rdata_q;
    assign commit_pending_o   = pending_q;
    assign frame_cnt_o        = frame_cnt_q;
    assign spaceship_x_o      = ship_x_q;
    assign spaceship_y_o      = ship_y_q;
    assign planet_x_o         = planet_x_q;
    assign planet_y_o         = planet_y_q;
    assign spaceship_bitmap_o = ship_bmp_q;
    assign planet_bitmap_o    = planet_bmp_q;

endmodule
